tone_synth: RTL and testbench



---
 rtl/tone_synth.sv | 151 +++++++++++++++
 tb/tb_tone_synth.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_synth.sv
// -----------------------------------------------------------------------------
// tone_synth
//
// Square/pulse-wave tone generator for a piezo speaker. A note code selects a
// half-period count from a table built at elaboration from CLK_HZ. Volume is
// set by narrowing the high part of each period. New note/volume values are
// taken only at period boundaries (or straight from IDLE), so the waveform
// never glitches mid-period.
//
// Parameters:
//   CLK_HZ       system clock frequency in Hz
//   CW           period counter width; must hold 2*CLK_HZ/(2*262)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   note         0 = rest, 1..21 = C4..B6, 22..31 = rest
//   vol          0 = mute, 1 = 12.5 %, 2 = 25 %, 3 = 50 % duty
//   speaker      tone output
//   busy         high while a tone is playing
//   note_cur     note code currently sounding (0 when idle)
//   period_tick  one-cycle pulse on the last cycle of each tone period
// -----------------------------------------------------------------------------
module tone_synth #(
   parameter int CLK_HZ = 100_000_000,
   parameter int CW     = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] note,
   input  logic [1:0] vol,
   output logic       speaker,
   output logic       busy,
   output logic [4:0] note_cur,
   output logic       period_tick
);

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   // Every branch is a constant expression, so this folds to a ROM of
   // literals; no divider is built.
   function automatic logic [CW-1:0] half_count(input logic [4:0] n);
      case (n)
         5'd1:    half_count = CW'(CLK_HZ / (2 * 262));
         5'd2:    half_count = CW'(CLK_HZ / (2 * 294));
         5'd3:    half_count = CW'(CLK_HZ / (2 * 330));
         5'd4:    half_count = CW'(CLK_HZ / (2 * 349));
         5'd5:    half_count = CW'(CLK_HZ / (2 * 392));
         5'd6:    half_count = CW'(CLK_HZ / (2 * 440));
         5'd7:    half_count = CW'(CLK_HZ / (2 * 494));
         5'd8:    half_count = CW'(CLK_HZ / (2 * 523));
         5'd9:    half_count = CW'(CLK_HZ / (2 * 587));
         5'd10:   half_count = CW'(CLK_HZ / (2 * 659));
         5'd11:   half_count = CW'(CLK_HZ / (2 * 698));
         5'd12:   half_count = CW'(CLK_HZ / (2 * 784));
         5'd13:   half_count = CW'(CLK_HZ / (2 * 880));
         5'd14:   half_count = CW'(CLK_HZ / (2 * 988));
         5'd15:   half_count = CW'(CLK_HZ / (2 * 1047));
         5'd16:   half_count = CW'(CLK_HZ / (2 * 1175));
         5'd17:   half_count = CW'(CLK_HZ / (2 * 1319));
         5'd18:   half_count = CW'(CLK_HZ / (2 * 1397));
         5'd19:   half_count = CW'(CLK_HZ / (2 * 1568));
         5'd20:   half_count = CW'(CLK_HZ / (2 * 1760));
         5'd21:   half_count = CW'(CLK_HZ / (2 * 1976));
         default: half_count = '0;
      endcase
   endfunction

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] period_q;
   logic [CW-1:0] high_q;
   logic [4:0]    note_cur_q;

   logic [CW-1:0] half_d;
   logic [CW-1:0] period_d;
   logic [CW-1:0] high_d;
   logic          valid;
   logic          last;

   // Candidate values to load at the next start or wrap.
   assign valid    = (note >= 5'd1) && (note <= 5'd21) && (vol != 2'd0);
   assign half_d   = half_count(note);
   assign period_d = {half_d[CW-2:0], 1'b0};

   // High time is the period shifted right by (4 - vol).
   always_comb begin
      // NOTE: default first so every path assigns high_d and no latch is inferred.
      high_d = '0;
      case (vol)
         2'd3:    high_d = period_d >> 1;
         2'd2:    high_d = period_d >> 2;
         2'd1:    high_d = period_d >> 3;
         default: high_d = '0;
      endcase
   end

   // period_q is never 0 in PLAY, so this never compares against a wrapped value.
   assign last = (cnt_q == period_q - CW'(1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         period_q   <= '0;
         high_q     <= '0;
         note_cur_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (valid) begin
                  period_q   <= period_d;
                  high_q     <= high_d;
                  note_cur_q <= note;
                  state_q    <= PLAY;
               end
            end
            PLAY: begin
               if (last) begin
                  // Inputs are only looked at here, at the period wrap.
                  cnt_q <= '0;
                  if (valid) begin
                     period_q   <= period_d;
                     high_q     <= high_d;
                     note_cur_q <= note;
                  end else begin
                     note_cur_q <= '0;
                     state_q    <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Outputs depend on registers only; no input-to-output path.
   assign busy        = (state_q == PLAY);
   assign speaker     = (state_q == PLAY) && (cnt_q < high_q);
   assign period_tick = (state_q == PLAY) && last;
   assign note_cur    = note_cur_q;

endmodule

// File: tb/tb_tone_synth.sv
// -----------------------------------------------------------------------------
// tb_tone_synth
//
// Directed bench for tone_synth at CLK_HZ = 1 MHz. A time-based reference
// model (absolute cycle number minus period start cycle) predicts all outputs
// and is compared with the DUT on every falling edge. Directed sequences
// additionally measure period lengths and high times on the DUT and compare
// them with hand-computed numbers.
// -----------------------------------------------------------------------------
module tb_tone_synth;

   localparam int CLK_HZ = 1_000_000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] note = 5'd0;
   logic [1:0] vol = 2'd0;
   logic       speaker;
   logic       busy;
   logic [4:0] note_cur;
   logic       period_tick;

   int total = 0;
   int bad   = 0;

   tone_synth #(.CLK_HZ(CLK_HZ), .CW(20)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .note        (note),
      .vol         (vol),
      .speaker     (speaker),
      .busy        (busy),
      .note_cur    (note_cur),
      .period_tick (period_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: no period_tick within cycle budget (t=%0t)", name, $time);
   endtask

   // ---------------------------------------------------------------- model
   int freq_tab [22] = '{0, 262, 294, 330, 349, 392, 440, 494,
                            523, 587, 659, 698, 784, 880, 988,
                            1047, 1175, 1319, 1397, 1568, 1760, 1976};

   function automatic int m_half(input int n);
      if (n >= 1 && n <= 21) return CLK_HZ / (2 * freq_tab[n]);
      return 0;
   endfunction

   function automatic bit m_valid(input int n, input int v);
      return (n >= 1) && (n <= 21) && (v != 0);
   endfunction

   bit m_play  = 1'b0;
   int m_note  = 0;
   int m_p     = 0;
   int m_high  = 0;
   int cycle   = 0;
   int m_start = 0;

   // Position inside the current period is (cycle - m_start).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_play  = 1'b0;
         m_note  = 0;
         cycle   = 0;
         m_start = 0;
      end else begin
         int pos;
         pos = cycle - m_start;
         cycle++;
         if (!m_play || pos == m_p - 1) begin
            if (m_valid(note, vol)) begin
               m_play  = 1'b1;
               m_note  = note;
               m_p     = 2 * m_half(note);
               m_high  = m_p / (1 << (4 - vol));
               m_start = cycle;
            end else begin
               m_play = 1'b0;
               m_note = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      int pos;
      pos = cycle - m_start;
      check("cyc_busy",     busy,        m_play);
      check("cyc_speaker",  speaker,     m_play && (pos < m_high));
      check("cyc_tick",     period_tick, m_play && (pos == m_p - 1));
      check("cyc_note_cur", note_cur,    m_play ? m_note : 0);
   end

   // ------------------------------------------------------------ helpers
   // Advance to the next falling edge that shows period_tick.
   task automatic wait_tick(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         @(negedge clk);
         if (period_tick === 1'b1) seen = 1'b1;
      end
      if (!seen) timeout(name);
   endtask

   // Count cycles and high cycles up to and including the next tick. When
   // change_at is positive, note is set to new_note on that counted cycle.
   task automatic count_to_tick(input string name, input int change_at,
                                input logic [4:0] new_note,
                                output int len, output int hi);
      bit seen = 1'b0;
      len = 0;
      hi  = 0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         @(negedge clk);
         len++;
         if (speaker === 1'b1) hi++;
         if (len == change_at) note = new_note;
         if (period_tick === 1'b1) seen = 1'b1;
      end
      if (!seen) timeout(name);
   endtask

   // ---------------------------------------------------------- stimulus
   initial begin
      int len, hi, act;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_speaker", speaker, 1'b0);
      check("rst_note_cur", note_cur, 5'd0);
      check("rst_tick", period_tick, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: A5 at full volume from IDLE.
      note = 5'd13; vol = 2'd3;
      wait_tick("t1_wait");
      count_to_tick("t1_count", -1, 5'd0, len, hi);
      check("t1_period", len, 1136);
      check("t1_high", hi, 568);
      check("t1_model_p", m_p, 1136);
      check("t1_model_high", m_high, 568);
      check("t1_busy", busy, 1'b1);
      check("t1_note_cur", note_cur, 5'd13);

      // 2: A4 at 12.5 % duty (taken at the wrap that follows).
      note = 5'd6; vol = 2'd1;
      wait_tick("t2_wait");
      count_to_tick("t2_count", -1, 5'd0, len, hi);
      check("t2_period", len, 2272);
      check("t2_high", hi, 284);
      check("t2_model_high", m_high, 284);
      check("t2_note_cur", note_cur, 5'd6);

      // 3: change to C5 at cnt=100; old period completes unchanged.
      count_to_tick("t3_old", 101, 5'd8, len, hi);
      check("t3_old_period", len, 2272);
      check("t3_old_high", hi, 284);
      count_to_tick("t3_new", -1, 5'd0, len, hi);
      check("t3_new_period", len, 1912);
      check("t3_new_high", hi, 239);
      check("t3_note_cur", note_cur, 5'd8);

      // 4: rest mid-period; current period finishes, then IDLE.
      count_to_tick("t4_last", 500, 5'd0, len, hi);
      check("t4_last_period", len, 1912);
      check("t4_last_high", hi, 239);
      @(negedge clk);
      check("t4_busy", busy, 1'b0);
      check("t4_speaker", speaker, 1'b0);
      check("t4_note_cur", note_cur, 5'd0);

      // 5: out-of-range code and muted volume are both rests.
      note = 5'd25; vol = 2'd3;
      act = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy !== 1'b0 || speaker !== 1'b0) act++;
      end
      check("t5_code25_active", act, 0);
      note = 5'd10; vol = 2'd0;
      act = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy !== 1'b0 || speaker !== 1'b0) act++;
      end
      check("t5_vol0_active", act, 0);

      // 6: C6, reset at cnt=300, restart with a full period.
      note = 5'd15; vol = 2'd3;
      @(negedge clk);                  // loaded: this cycle has cnt=0
      check("t6_busy_start", busy, 1'b1);
      check("t6_model_p", m_p, 954);
      repeat (300) @(negedge clk);     // cnt=300
      check("t6_pre_speaker", speaker, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_speaker", speaker, 1'b0);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_note_cur", note_cur, 5'd0);
      check("t6_rst_tick", period_tick, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      begin
         bit seen = 1'b0;
         len = 0;
         hi  = 0;
         for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) len++;
            if (speaker === 1'b1) hi++;
            if (period_tick === 1'b1) seen = 1'b1;
         end
         if (!seen) timeout("t6_restart");
      end
      check("t6_restart_period", len, 954);
      check("t6_restart_high", hi, 477);
      check("t6_note_cur", note_cur, 5'd15);

      note = 5'd0;
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
